// File: rtl/voice_mixer.sv
// Polls each synth voice once per sample tick, sums, applies master volume and saturates.
// Optional MIXER_SOFT_MUTE_EN: effective volume ramps by 1 per mix toward its target.
module voice_mixer #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned VOL_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_tick,
    output logic                          voice_req,
    output logic [$clog2(NUM_VOICES)-1:0] voice_idx,
    input  logic                          voice_valid,
    input  logic [SAMPLE_W-1:0]           voice_sample,
    input  logic                          voice_active,
    input  logic [VOL_W-1:0]              master_vol,
    input  logic                          mute,
    input  logic                          clear_flags,
    output logic [SAMPLE_W-1:0]           mix_out,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          clip,
    output logic                          overrun
);

    localparam int unsigned IDX_W  = $clog2(NUM_VOICES);
    localparam int unsigned ACC_W  = SAMPLE_W + IDX_W;
    localparam int unsigned PROD_W = ACC_W + VOL_W + 1;
    localparam int unsigned SH_W   = PROD_W - VOL_W;

    localparam logic [IDX_W-1:0]       LastIdx = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [SH_W-1:0] SatMax  = SH_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [SH_W-1:0] SatMin  = ~SatMax;

    typedef enum logic [2:0] {StIdle, StReq, StScale, StSat, StOut} state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       req_q, req_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SH_W-1:0]     prod_q, prod_d;
    logic [SAMPLE_W-1:0]        mix_out_q, mix_out_d;
    logic                       mix_valid_q, mix_valid_d;
    logic                       busy_q, busy_d;
    logic                       clip_q, clip_d;
    logic                       overrun_q, overrun_d;
    logic [VOL_W-1:0]           eff_vol;
    logic signed [PROD_W-1:0]   prod_full;
    logic signed [SH_W-1:0]     shifted;
    logic                       unused_prod_lsb;

`ifdef MIXER_SOFT_MUTE_EN
    logic [VOL_W-1:0] vol_q, vol_d;
    logic [VOL_W-1:0] vol_target;
    assign vol_target = mute ? '0 : master_vol;
    assign eff_vol    = vol_q;
`else
    assign eff_vol = mute ? '0 : master_vol;
`endif

    // Unsigned volume is zero-extended so the product stays a signed multiply.
    assign prod_full = $signed({{(PROD_W - ACC_W){acc_q[ACC_W-1]}}, acc_q})
                     * $signed({{(PROD_W - VOL_W){1'b0}}, eff_vol});
    assign unused_prod_lsb = ^prod_full[VOL_W-1:0];
    assign shifted = prod_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        req_d       = req_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        clip_d      = clear_flags ? 1'b0 : clip_q;
        overrun_d   = clear_flags ? 1'b0 : overrun_q;
`ifdef MIXER_SOFT_MUTE_EN
        vol_d       = vol_q;
`endif
        if (sample_tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (sample_tick) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (voice_valid) begin
                    if (voice_active) begin
                        acc_d = acc_q + $signed({{(ACC_W - SAMPLE_W){voice_sample[SAMPLE_W-1]}},
                                                 voice_sample});
                    end
                    if (idx_q == LastIdx) begin
                        req_d   = 1'b0;
                        state_d = StScale;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StScale: begin
                // Keeping only the upper bits is the floor arithmetic shift by VOL_W.
                prod_d  = prod_full[PROD_W-1:VOL_W];
                state_d = StSat;
            end
            StSat: begin
                if (shifted > SatMax) begin
                    mix_out_d = SatMax[SAMPLE_W-1:0];
                    clip_d    = 1'b1;
                end else if (shifted < SatMin) begin
                    mix_out_d = SatMin[SAMPLE_W-1:0];
                    clip_d    = 1'b1;
                end else begin
                    mix_out_d = shifted[SAMPLE_W-1:0];
                end
                mix_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
`ifdef MIXER_SOFT_MUTE_EN
                if (vol_q < vol_target) begin
                    vol_d = vol_q + 1'b1;
                end else if (vol_q > vol_target) begin
                    vol_d = vol_q - 1'b1;
                end
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            req_q       <= 1'b0;
            acc_q       <= '0;
            prod_q      <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef MIXER_SOFT_MUTE_EN
            vol_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            req_q       <= req_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            busy_q      <= busy_d;
            clip_q      <= clip_d;
            overrun_q   <= overrun_d;
`ifdef MIXER_SOFT_MUTE_EN
            vol_q       <= vol_d;
`endif
        end
    end

    assign voice_req = req_q;
    assign voice_idx = idx_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign busy      = busy_q;
    assign clip      = clip_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
Upstream neighbour of the codec audio controller. Once per sample period it polls every synth voice over a request/valid handshake and sums their signed samples. It then applies master volume, saturates the result and presents one signed 16-bit mixed sample with a 1-cycle valid strobe. The serializer latches this sample for the DAC. All logic runs in the single clk domain.

Parameters:
NUM_VOICES, 8, voices polled per sample; power of two, 2..32
SAMPLE_W, 16, voice and output sample width (signed two's complement)
VOL_W, 8, master volume width (unsigned); gain = master_vol / 2^VOL_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low
sample_tick  in  1  1-cycle pulse at the sample rate; starts a mix
voice_req  out  1  request sample of voice voice_idx
voice_idx  out  $clog2(NUM_VOICES)  voice being requested
voice_valid  in  1  voice_sample/voice_active valid for voice_idx
voice_sample  in  SAMPLE_W  signed sample of requested voice
voice_active  in  1  0 = voice silent, contributes 0
master_vol  in  VOL_W  master volume, sampled in SCALE state
mute  in  1  mute request
clear_flags  in  1  clears clip and overrun
mix_out  out  SAMPLE_W  mixed sample, held until next update
mix_valid  out  1  1-cycle strobe, mix_out updated the same cycle
busy  out  1  high whenever FSM is not IDLE
clip  out  1  sticky: a result saturated
overrun  out  1  sticky: sample_tick arrived while busy

Behaviour:
- Reset (reset==0 at posedge clk): FSM to IDLE. voice_req=0, voice_idx=0, mix_out=0, mix_valid=0, busy=0, clip=0, overrun=0, accumulator=0. Reset mid-mix abandons the mix with no mix_valid.
- Accumulator is signed, ACC_W = SAMPLE_W + $clog2(NUM_VOICES) bits (19 at defaults). It cannot overflow.
- IDLE: on sample_tick, clear accumulator, voice_idx=0, go to REQ.
- REQ: voice_req=1. Each cycle with voice_valid=1, add voice_sample (sign-extended) if voice_active=1, else add 0.
  - If voice_idx < NUM_VOICES-1, increment voice_idx; voice_req stays high.
  - Otherwise go to SCALE; voice_req=0 from the next cycle.
  - voice_valid outside REQ is ignored.
- SCALE: product = accumulator × {1'b0, effective_vol}, signed, ACC_W+VOL_W+1 bits.
  - effective_vol = 0 if mute, else master_vol.
- SAT: arithmetic shift right by VOL_W (floor). Clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. Set clip if clamped.
- OUT: load mix_out, pulse mix_valid for 1 cycle, go to IDLE.
- Latency: tick at cycle T; voice_valid arrives D cycles after voice_req presents each index. mix_valid is asserted at T + NUM_VOICES·(D+1) + 3. At defaults with D=0 this is T+11.
- sample_tick while busy: tick dropped, overrun=1, current mix unaffected. A tick in the same cycle as the OUT→IDLE transition is also dropped and flagged.
- clear_flags clears clip and overrun. A set event in the same cycle wins.
- busy=1 from the cycle after the accepted tick through the OUT cycle inclusive.

Optional Feature:
MIXER_SOFT_MUTE_EN.
- Defined: effective_vol is a register stepping by 1 per completed mix (in OUT) toward the target. Target is 0 when mute=1, else master_vol. SCALE uses the register value. Reset value is 0.
- Undefined: effective_vol switches immediately, as described in SCALE.

Test Plan:
1. Defaults, D=0. All 8 voices active at 1000, master_vol=128, tick at T → mix_valid at T+11, mix_out=4000, clip=0.
2. All voices 32767, vol=255 → mix_out=32767, clip=1. Then all voices -32768 → mix_out=-32768. clear_flags → clip=0.
3. Voices 0-3 active at 2000; voices 4-7 inactive carrying 30000; vol=255 → mix_out=7968.
4. D=3 wait states, same stimulus as test 1 → mix_out=4000, mix_valid at T+35. voice_idx steps 0..7, each held 4 cycles.
5. Second tick at T+5 during a mix → overrun=1, exactly one mix_valid, mix_out=4000. Then a tick at T+11 is dropped and flagged. A tick at T+12 is accepted.
6. reset=0 at T+4 mid-REQ → next cycle voice_req=0, busy=0, mix_out=0, no mix_valid. Next tick gives a correct mix. With MIXER_SOFT_MUTE_EN defined and mute=1 from vol=4 → output decays over 4 samples to 0.
